// File: rtl/ps2_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_receiver
// Purpose  : PS/2 device-to-host frame receiver. Synchronizes the raw PS/2
//            clock and data pins, detects PS/2 clock falling edges, shifts in
//            the 11-bit frame (start, 8 data bits LSB-first, odd parity,
//            stop), validates it and presents the scan code with a one-cycle
//            strobe, or flags a parity or framing/timeout error.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            ps2_clk    - raw PS/2 clock pin (asynchronous)
//            ps2_data   - raw PS/2 data pin (asynchronous)
//            data       - last valid scan code (held until next valid frame)
//            valid      - one-cycle strobe, data is new
//            parity_err - one-cycle strobe, frame had bad parity
//            frame_err  - one-cycle strobe, bad stop bit or inter-edge timeout
//            busy       - high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_receiver #(
  parameter int TIMEOUT    = 5000,
  parameter int FRAME_BITS = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]     BITS_LAST = 4'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [10:0]     sr, sr_next;
  logic [3:0]      bit_cnt, bit_cnt_next;
  logic [TW-1:0]   to_cnt, to_cnt_next;
  logic [7:0]      data_next;
  logic            valid_next, parity_err_next, frame_err_next;

  // Synchronizers; the clock path has a third stage for edge detection.
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;
  logic bit_in;

  // Flops reset high so an idle bus does not look like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall   = clk_s3 & ~clk_s2;
  assign bit_in = dat_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      bit_cnt    <= bit_cnt_next;
      to_cnt     <= to_cnt_next;
      data       <= data_next;
      valid      <= valid_next;
      parity_err <= parity_err_next;
      frame_err  <= frame_err_next;
      busy       <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next      = state;
    sr_next         = sr;
    bit_cnt_next    = bit_cnt;
    to_cnt_next     = to_cnt;
    data_next       = data;
    valid_next      = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;

    case (state)
      IDLE: begin
        // A falling edge with data high is a glitch/false start: ignore it.
        if (fall && !bit_in) begin
          sr_next      = {bit_in, sr[10:1]};
          bit_cnt_next = 4'd1;
          to_cnt_next  = '0;
          state_next   = RECEIVE;
        end
      end

      RECEIVE: begin
        // An edge arriving in the timeout cycle still counts as progress.
        if (fall) begin
          sr_next      = {bit_in, sr[10:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          to_cnt_next  = '0;
          if ((bit_cnt + 4'd1) == BITS_LAST) begin
            state_next = CHECK;
          end
        end else if (to_cnt == TO_LAST) begin
          frame_err_next = 1'b1;
          bit_cnt_next   = '0;
          to_cnt_next    = '0;
          state_next     = IDLE;
        end else begin
          to_cnt_next = to_cnt + 1'b1;
        end
      end

      CHECK: begin
        bit_cnt_next = '0;
        state_next   = IDLE;
        // A bad stop bit outranks a parity error; errors leave data intact.
        if (!sr[10]) begin
          frame_err_next = 1'b1;
        end else if (^sr[9:1]) begin
          data_next  = sr[8:1];
          valid_next = 1'b1;
        end else begin
          parity_err_next = 1'b1;
        end
      end

      default: begin
        bit_cnt_next = '0;
        to_cnt_next  = '0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Front-end stage of the keyboard path; directly upstream of the 11-edge frame-count logic.
- Synchronizes the raw PS/2 clock and data pins and detects PS/2 clock falling edges.
- Shifts in the 11-bit PS/2 frame: start, 8 data bits LSB-first, odd parity, stop.
- Validates the frame and presents the scan-code byte with a one-cycle valid strobe, or a one-cycle error strobe.

Parameters:
- TIMEOUT, 5000: system clock cycles without a PS/2 falling edge before a partial frame is abandoned (100 us at 50 MHz).
- FRAME_BITS, 11: bits per PS/2 frame; fixed by protocol, exposed for bench scaling only.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- data  output  8  last valid scan code.
- valid  output  1  one-cycle strobe; data is new.
- parity_err  output  1  one-cycle strobe; frame received with bad parity.
- frame_err  output  1  one-cycle strobe; bad stop bit or timeout.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data=8'h00, valid=parity_err=frame_err=0, busy=0, shift register=0, bit counter=0, timeout counter=0. Synchronizer flops reset to 1 (bus idle high).
- Synchronizer: 2 flops per pin (s1, s2), plus a 3rd flop on the clock path (s3).
- fall = s3 & ~s2; it is high for exactly 1 cycle per PS/2 falling edge.
- Sampled bit = s2 of data, taken in the fall cycle.
- Shift register: 11 bits, shifts right, new bit enters at MSB. After 11 shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
- Bit counter: 4 bits. Timeout counter: clog2(TIMEOUT) bits.
- IDLE:
  - fall with bit=0 -> shift it in, bit_cnt=1, clear timeout counter, go to RECEIVE.
  - fall with bit=1 -> false start; ignored, stay in IDLE, no error.
- RECEIVE:
  - fall -> shift bit in, bit_cnt+1, clear timeout counter. If bit_cnt becomes FRAME_BITS -> go to CHECK.
  - no fall -> timeout counter +1. On reaching TIMEOUT-1 -> frame_err=1 for 1 cycle, go to IDLE, bit_cnt=0.
  - fall and timeout in the same cycle -> fall wins; counter clears, no error.
- CHECK (exactly 1 cycle; fall ignored):
  - Parity ok: XOR of sr[9:1] = 1. Stop ok: sr[10] = 1.
  - Both ok -> data <= sr[8:1], valid=1.
  - Stop bad -> frame_err=1, data unchanged. This takes priority over a parity error.
  - Else parity bad -> parity_err=1, data unchanged.
  - Then go to IDLE.
- Strobes: valid, parity_err and frame_err are registered and mutually exclusive; each is high for exactly 1 cycle per event.
- busy: registered; high in RECEIVE and CHECK.
- Latency: valid/err asserts 4 rising clk edges after the first edge that samples ps2_clk low for the stop bit (2 sync + edge/shift + check).
- data holds its value until the next valid frame. Errors never corrupt data.
- Back-to-back frames: the next start bit is accepted in IDLE immediately after CHECK.

Test Plan:
- Frame for 0x1C (start 0, data bits 0,0,1,1,1,0,0,0, parity 0, stop 1), PS/2 half-period 100 clk -> data=8'h1C, valid 1 cycle, exactly 4 clk edges after stop-bit fall; no err; busy low afterwards.
- Same frame with parity=1 -> parity_err 1 cycle, valid=0, data keeps its previous value.
- 0x1C with stop=0 and parity also bad -> frame_err only; parity_err stays 0.
- Start plus 4 bits, then PS/2 clock stops, TIMEOUT=50 -> frame_err pulse 50 cycles after the last fall, state IDLE. A following good 0xF0 frame yields data=8'hF0, valid.
- Falling edge with data=1 while idle, then a good 0x5A frame -> no error; only valid with data=8'h5A.
- reset low after 6 bits of a frame -> all outputs 0 immediately (asynchronously); remaining edges of that frame are taken as a false start or abandoned by timeout with frame_err, never valid. The next full 0x29 frame gives valid with data=8'h29.
